// File: rtl/interface_buffer_pkg.sv
// Shared constants and helpers for the interface_buffer elastic channel
// and its storage array.
package interface_buffer_pkg;

    localparam int IB_DEFAULT_WIDTH = 64;
    localparam int IB_DEFAULT_DEPTH = 2;

    // Pointer width is at least one bit so a single-entry buffer still has a legal index.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/interface_buffer_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port, no reset. Reusable by any buffered channel.
module interface_buffer_mem
    import interface_buffer_pkg::*;
#(
    parameter int WIDTH = IB_DEFAULT_WIDTH,
    parameter int DEPTH = IB_DEFAULT_DEPTH,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [PW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [PW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/interface_buffer.sv
// Ready/valid elastic buffer holding up to DEPTH beats, with optional
// zero-latency bypass while empty and an exported occupancy count.
module interface_buffer
    import interface_buffer_pkg::*;
#(
    parameter int WIDTH  = IB_DEFAULT_WIDTH,
    parameter int DEPTH  = IB_DEFAULT_DEPTH,
    parameter bit BYPASS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int            PW       = ptr_width(DEPTH);
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty;
    logic             push;
    logic             pop;
    logic             bypass_beat;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] mem_rd_data;

    // in_ready looks only at registered occupancy, so a pop on a full buffer
    // frees the slot for the following cycle rather than the current one.
    assign empty     = (count_q == '0);
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = empty ? (BYPASS & in_valid) : 1'b1;
    assign out_data  = (BYPASS && empty) ? in_data : mem_rd_data;

    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign bypass_beat = BYPASS & empty & in_valid & out_ready;
    assign wr_en       = push & ~bypass_beat;
    assign rd_en       = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

    interface_buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rd_data)
    );

endmodule
